// File: rtl/rapids_pkg.sv
// Shared constants, fetch-state encoding and queue-entry layout for the instruction prefetcher.
package rapids_pkg;

    localparam logic [31:0] INITIAL_ADDR = 32'd16;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } pf_state_t;

    // 65-bit queue entry: instruction word, its byte address, and the MMU fault flag
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        segv;
    } pf_entry_t;

endpackage

// File: rtl/instr_prefetch_if.sv
// MMU instruction-port request bus plus the head-of-queue instruction bus to the controlpath.
interface instr_prefetch_if;

    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] instr_in;
    logic        wait_instr;
    logic        instr_segv;

    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        segv_out;
    logic        instr_take;

    modport master (
        output fetch_req, fetch_addr, instr_out, pc_out, instr_valid, segv_out,
        input  instr_in, wait_instr, instr_segv, instr_take
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_out, pc_out, instr_valid, segv_out,
        output instr_in, wait_instr, instr_segv, instr_take
    );

endinterface

// File: rtl/instr_prefetch_prefetch_fifo.sv
// DEPTH-entry circular queue of fetched words; registered read of the head, push refused when full.
// Flush clears pointers and count in one cycle and overrides any push or pop in the same cycle.
module prefetch_fifo
    import rapids_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  pf_entry_t       wdata_i,
    output pf_entry_t       rdata_o,
    output logic [CW-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    pf_entry_t         mem [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i  && !flush_i && (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: fetch FSM and address counter feeding prefetch_fifo; accepted words visible next cycle.
// Requests stop when the queue is full or after an MMU fault; redirect flushes and overrides accept/take.
module instr_prefetch
    import rapids_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] INITIAL_ADDR = rapids_pkg::INITIAL_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic                   redirect,
    input  logic [31:0]            redirect_addr,
    instr_prefetch_if.master       bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_t      state_q, state_d;
    logic [31:0]    fetch_addr_q, fetch_addr_d;
    logic [CW-1:0]  fifo_count;
    pf_entry_t      head, tail_entry;
    logic           fetch_req, accept, take, head_vld;

    // Request depends only on registered state and occupancy, never on instr_take
    assign fetch_req = (state_q == FETCH) && (fifo_count < CW'(DEPTH));
    assign accept    = fetch_req && !bus.wait_instr;
    assign head_vld  = (fifo_count != '0);
    assign take      = bus.instr_take && head_vld;

    assign tail_entry = '{instr: bus.instr_in, addr: fetch_addr_q, segv: bus.instr_segv};

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        unique case (state_q)
            IDLE:    if (redirect || go) state_d = FETCH;
            FETCH:   if (!redirect && accept && bus.instr_segv) state_d = FAULT;
            FAULT:   if (redirect) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_addr_d = {redirect_addr[31:2], 2'b00};
        end else if (accept) begin
            fetch_addr_d = fetch_addr_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= INITIAL_ADDR;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (accept && !redirect),
        .pop_i   (take && !redirect),
        .flush_i (redirect),
        .wdata_i (tail_entry),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    assign bus.fetch_req   = fetch_req;
    assign bus.fetch_addr  = fetch_addr_q;
    assign bus.instr_valid = head_vld;
    assign bus.instr_out   = head_vld ? head.instr : 32'd0;
    assign bus.pc_out      = head_vld ? head.addr  : fetch_addr_q;
    assign bus.segv_out    = head_vld ? head.segv  : 1'b0;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: port checks in the stimulus thread, drained entries checked by a scoreboard monitor.
module tb_instr_prefetch;
    import rapids_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        segv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, go, redirect, segv_en;
    logic [31:0] redirect_addr, segv_addr;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    instr_prefetch_if bus ();

    instr_prefetch #(.DEPTH(4), .INITIAL_ADDR(32'd16)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    // MMU model: word at address 16 is A0000001, each following word increments by one
    function automatic logic [31:0] mmu_word(input logic [31:0] a);
        return 32'hA000_0001 + ((a - 32'd16) >> 2);
    endfunction

    assign bus.instr_in   = mmu_word(bus.fetch_addr);
    assign bus.instr_segv = segv_en && (bus.fetch_addr == segv_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] addr, input logic segv);
        exp_t e;
        e.instr = instr;
        e.addr  = addr;
        e.segv  = segv;
        return e;
    endfunction

    // Scoreboard monitor: every head the DUT hands over on a take must match the next expected entry
    always @(negedge clk) begin
        if (!reset && !redirect && bus.instr_take && bus.instr_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc %h expected no entry", bus.pc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", bus.instr_out, e.instr);
                chk("sb_pc", bus.pc_out, e.addr);
                chk("sb_segv", 32'(bus.segv_out), 32'(e.segv));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; go = 1'b0; redirect = 1'b0; redirect_addr = '0;
        segv_en = 1'b0; segv_addr = '0;
        bus.wait_instr = 1'b0; bus.instr_take = 1'b0;
        #12;
        chk("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr_out", bus.instr_out, 32'd0);
        chk("rst_segv_out", 32'(bus.segv_out), 32'd0);
        chk("rst_pc_out", bus.pc_out, 32'd16);
        chk("rst_fetch_addr", bus.fetch_addr, 32'd16);

        // Fill the queue from reset
        reset = 1'b0; go = 1'b1;
        tick(); go = 1'b0;
        chk("go_fetch_req", 32'(bus.fetch_req), 32'd1);
        chk("go_fetch_addr", bus.fetch_addr, 32'd16);
        chk("go_valid", 32'(bus.instr_valid), 32'd0);
        sb.push_back(mk(32'hA000_0001, 32'd16, 1'b0));
        sb.push_back(mk(32'hA000_0002, 32'd20, 1'b0));
        sb.push_back(mk(32'hA000_0003, 32'd24, 1'b0));
        sb.push_back(mk(32'hA000_0004, 32'd28, 1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fill_fetch_addr", bus.fetch_addr, 32'd20 + 32'(4 * i));
            chk("fill_instr_out", bus.instr_out, 32'hA000_0001);
            chk("fill_pc_out", bus.pc_out, 32'd16);
        end
        chk("full_fetch_req", 32'(bus.fetch_req), 32'd0);
        tick();
        chk("full_hold_addr", bus.fetch_addr, 32'd32);
        chk("full_count", 32'(dut.fifo_count), 32'd4);

        // Drain with the MMU stalled; the fifth take hits an empty queue
        bus.wait_instr = 1'b1; bus.instr_take = 1'b1;
        repeat (5) tick();
        bus.instr_take = 1'b0;
        chk("drain_valid", 32'(bus.instr_valid), 32'd0);
        chk("drain_count", 32'(dut.fifo_count), 32'd0);
        chk("drain_pc_out", bus.pc_out, 32'd32);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        // MMU stall at address 20
        redirect = 1'b1; redirect_addr = 32'd20;
        tick(); redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_fetch_addr", bus.fetch_addr, 32'd20);
            chk("wait_valid", 32'(bus.instr_valid), 32'd0);
        end
        bus.wait_instr = 1'b0;
        sb.push_back(mk(32'hA000_0002, 32'd20, 1'b0));
        sb.push_back(mk(32'hA000_0003, 32'd24, 1'b0));
        sb.push_back(mk(32'hA000_0004, 32'd28, 1'b0));
        tick();
        chk("wait_accept_addr", bus.fetch_addr, 32'd24);
        chk("wait_accept_pc", bus.pc_out, 32'd20);
        tick();
        chk("two_count", 32'(dut.fifo_count), 32'd2);

        // Accept and take together at count 2
        bus.instr_take = 1'b1;
        tick();
        bus.instr_take = 1'b0; bus.wait_instr = 1'b1;
        chk("simul_count", 32'(dut.fifo_count), 32'd2);
        chk("simul_pc_out", bus.pc_out, 32'd24);
        chk("simul_fetch_addr", bus.fetch_addr, 32'd32);

        // Redirect with a same-cycle accept at 32 that must be discarded
        redirect = 1'b1; redirect_addr = 32'h0000_0103; bus.wait_instr = 1'b0;
        sb.delete();
        tick();
        redirect = 1'b0; bus.wait_instr = 1'b1;
        chk("redir_valid", 32'(bus.instr_valid), 32'd0);
        chk("redir_fetch_addr", bus.fetch_addr, 32'h0000_0100);
        chk("redir_count", 32'(dut.fifo_count), 32'd0);
        bus.wait_instr = 1'b0;
        tick();
        bus.wait_instr = 1'b1;
        chk("redir_pc_out", bus.pc_out, 32'h0000_0100);
        chk("redir_instr_out", bus.instr_out, 32'hA000_003D);
        chk("redir_count1", 32'(dut.fifo_count), 32'd1);

        // MMU fault at address 24
        redirect = 1'b1; redirect_addr = 32'd16; bus.wait_instr = 1'b0;
        segv_en = 1'b1; segv_addr = 32'd24;
        tick(); redirect = 1'b0;
        sb.push_back(mk(32'hA000_0001, 32'd16, 1'b0));
        sb.push_back(mk(32'hA000_0002, 32'd20, 1'b0));
        sb.push_back(mk(32'hA000_0003, 32'd24, 1'b1));
        repeat (3) tick();
        chk("fault_state", 32'(dut.state_q), 32'(FAULT));
        chk("fault_fetch_req", 32'(bus.fetch_req), 32'd0);
        tick();
        chk("fault_hold_addr", bus.fetch_addr, 32'd28);
        chk("fault_count", 32'(dut.fifo_count), 32'd3);
        bus.instr_take = 1'b1;
        repeat (3) tick();
        bus.instr_take = 1'b0;
        chk("fault_drain_valid", 32'(bus.instr_valid), 32'd0);
        chk("fault_sb_empty", 32'(sb.size()), 32'd0);
        chk("fault_still_no_req", 32'(bus.fetch_req), 32'd0);

        // Recover from the fault with a redirect to 64
        redirect = 1'b1; redirect_addr = 32'd64; segv_en = 1'b0; bus.wait_instr = 1'b1;
        tick(); redirect = 1'b0;
        chk("resume_fetch_req", 32'(bus.fetch_req), 32'd1);
        chk("resume_fetch_addr", bus.fetch_addr, 32'd64);
        bus.wait_instr = 1'b0;
        tick();
        bus.wait_instr = 1'b1;
        chk("resume_pc_out", bus.pc_out, 32'd64);
        chk("resume_instr_out", bus.instr_out, 32'hA000_000D);

        // Address wrap at the top of memory
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; bus.wait_instr = 1'b0;
        tick(); redirect = 1'b0;
        tick();
        bus.wait_instr = 1'b1;
        chk("wrap_fetch_addr", bus.fetch_addr, 32'd0);
        chk("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);
        chk("wrap_instr_out", bus.instr_out, 32'hDFFF_FFFC);
        tick();
        chk("wrap_req_held", 32'(bus.fetch_req), 32'd1);

        // Reset asserted mid-request, between clock edges
        #2;
        reset = 1'b1;
        #1;
        chk("arst_fetch_req", 32'(bus.fetch_req), 32'd0);
        chk("arst_fetch_addr", bus.fetch_addr, 32'd16);
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_pc_out", bus.pc_out, 32'd16);
        sb.delete();
        tick();
        chk("arst_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        tick();
        chk("arst_idle_no_req", 32'(bus.fetch_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
